// File: rtl/pwm_to_pcm.sv
// PWM receive demodulator: counts synchronised high cycles over fixed 2^BIT_DEPTH-cycle
// frames and presents one saturated PCM word per frame on a single-entry valid/ready register.
module pwm_to_pcm #(
   parameter int BIT_DEPTH   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 pwm_clk,
   input  logic                 rst,
   input  logic                 pwm_in,
   input  logic                 pwm_valid_in,
   output logic [BIT_DEPTH-1:0] pcm_data,
   output logic                 pcm_valid,
   input  logic                 pcm_ready,
   output logic                 frame_err,
   output logic                 overrun
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [BIT_DEPTH-1:0] IDX_LAST = '1;

   logic [SYNC_STAGES-1:0] pwm_sync, vld_sync;
   logic                   pwm_s, valid_s;

   state_t                 state, state_nx;
   logic [BIT_DEPTH-1:0]   idx, idx_nx;
   logic [BIT_DEPTH:0]     high_cnt, cnt_nx, sum;
   logic [BIT_DEPTH-1:0]   sample;
   logic                   err_nx, done, load;

   always_ff @(posedge pwm_clk or posedge rst) begin
      if (rst) begin
         pwm_sync <= '0;
         vld_sync <= '0;
      end else begin
         pwm_sync <= {pwm_sync[SYNC_STAGES-2:0], pwm_in};
         vld_sync <= {vld_sync[SYNC_STAGES-2:0], pwm_valid_in};
      end
   end

   assign pwm_s   = pwm_sync[SYNC_STAGES-1];
   assign valid_s = vld_sync[SYNC_STAGES-1];

   // high_cnt is one bit wider so a fully-high frame reaches 2^BIT_DEPTH before clamping
   assign sum    = high_cnt + (BIT_DEPTH+1)'(pwm_s);
   assign sample = sum[BIT_DEPTH] ? '1 : sum[BIT_DEPTH-1:0];

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = high_cnt;
      err_nx   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (valid_s) begin
               cnt_nx   = (BIT_DEPTH+1)'(pwm_s);
               idx_nx   = BIT_DEPTH'(1);
               state_nx = MEASURE;
            end
         end
         MEASURE: begin
            if (!valid_s) begin
               state_nx = IDLE;
               idx_nx   = '0;
               cnt_nx   = '0;
               err_nx   = (idx != '0);
            end else if (idx == IDX_LAST) begin
               // stay in MEASURE so the next frame starts with no gap cycle
               done   = 1'b1;
               idx_nx = '0;
               cnt_nx = '0;
            end else begin
               idx_nx = idx + BIT_DEPTH'(1);
               cnt_nx = sum;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge pwm_clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         high_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nx;
         idx       <= idx_nx;
         high_cnt  <= cnt_nx;
         frame_err <= err_nx;
      end
   end

   assign load = done && (!pcm_valid || pcm_ready);

   always_ff @(posedge pwm_clk or posedge rst) begin
      if (rst) begin
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            pcm_data  <= sample;
            pcm_valid <= 1'b1;
         end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
         end
         if (done && pcm_valid && !pcm_ready)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pwm_to_pcm.sv
// Directed bench for pwm_to_pcm: frames of known duty, abort, back-pressure and mid-frame reset.
module tb_pwm_to_pcm;

   logic       pwm_clk = 1'b0;
   logic       rst = 1'b1;
   logic       pwm_in = 1'b0;
   logic       pwm_valid_in = 1'b0;
   logic [7:0] pcm_data;
   logic       pcm_valid;
   logic       pcm_ready = 1'b1;
   logic       frame_err;
   logic       overrun;

   pwm_to_pcm #(.BIT_DEPTH(8), .SYNC_STAGES(2)) dut (
      .pwm_clk(pwm_clk), .rst(rst), .pwm_in(pwm_in), .pwm_valid_in(pwm_valid_in),
      .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 pwm_clk = ~pwm_clk;

   int cyc = 0;
   always @(posedge pwm_clk) cyc <= cyc + 1;

   // accepted samples with the cycle they were seen, plus frame_err high cycles
   int q_data[$];
   int q_cyc[$];
   int err_cnt = 0;
   always @(negedge pwm_clk) begin
      if (!rst && pcm_valid && pcm_ready) begin
         q_data.push_back(int'(pcm_data));
         q_cyc.push_back(cyc);
      end
      if (frame_err) err_cnt++;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   int last_start;

   task automatic drive(input int n, input bit vld, input int highs);
      for (int i = 0; i < n; i++) begin
         @(posedge pwm_clk); #1;
         if (i == 0) last_start = cyc;
         pwm_valid_in = vld;
         pwm_in = vld && (i < highs);
      end
   endtask

   task automatic frame(input int highs);
      drive(256, 1'b1, highs);
   endtask

   task automatic idle(input int n);
      drive(n, 1'b0, 0);
   endtask

   int base, e0, s0, s1;

   initial begin
      // reset state
      repeat (3) @(posedge pwm_clk);
      @(negedge pwm_clk);
      chk("rst_data", int'(pcm_data), 0);
      chk("rst_valid", int'(pcm_valid), 0);
      chk("rst_err", int'(frame_err), 0);
      chk("rst_ovr", int'(overrun), 0);
      @(posedge pwm_clk); #1; rst = 1'b0;

      // single frame, 100 high; sample 258 cycles after first drive (2 sync + 256)
      idle(5);
      frame(100); s0 = last_start;
      idle(10);
      chk("t1_count", q_data.size(), 1);
      if (q_data.size() >= 1) begin
         chk("t1_data", q_data[0], 100);
         chk("t1_latency", q_cyc[0] - s0, 258);
      end
      chk("t1_err", err_cnt, 0);

      // back-to-back full high / full low
      base = q_data.size();
      frame(256); s0 = last_start;
      frame(0);
      idle(10);
      chk("t2_count", q_data.size() - base, 2);
      if (q_data.size() >= base + 2) begin
         chk("t2_sat", q_data[base], 255);
         chk("t2_lat", q_cyc[base] - s0, 258);
         chk("t2_zero", q_data[base+1], 0);
         chk("t2_gap", q_cyc[base+1] - q_cyc[base], 256);
      end
      chk("t2_err", err_cnt, 0);

      // three contiguous frames
      base = q_data.size();
      frame(10); frame(200); frame(255);
      idle(10);
      chk("t3_count", q_data.size() - base, 3);
      if (q_data.size() >= base + 3) begin
         chk("t3_d0", q_data[base], 10);
         chk("t3_d1", q_data[base+1], 200);
         chk("t3_d2", q_data[base+2], 255);
         chk("t3_gap01", q_cyc[base+1] - q_cyc[base], 256);
         chk("t3_gap12", q_cyc[base+2] - q_cyc[base+1], 256);
      end

      // abort at index 50
      base = q_data.size(); e0 = err_cnt;
      drive(50, 1'b1, 50);
      idle(10);
      chk("t4_err_pulse", err_cnt - e0, 1);
      chk("t4_no_sample", q_data.size() - base, 0);
      frame(37);
      idle(10);
      chk("t4_count", q_data.size() - base, 1);
      if (q_data.size() >= base + 1) chk("t4_data", q_data[base], 37);
      chk("t4_err_after", err_cnt - e0, 1);
      chk("t4_ovr", int'(overrun), 0);

      // back-pressure: second sample dropped, overrun sticky
      base = q_data.size();
      @(posedge pwm_clk); #1; pcm_ready = 1'b0;
      frame(60); frame(90);
      idle(10);
      chk("t5_valid", int'(pcm_valid), 1);
      chk("t5_data", int'(pcm_data), 60);
      chk("t5_ovr", int'(overrun), 1);
      @(posedge pwm_clk); #1; pcm_ready = 1'b1;
      @(posedge pwm_clk); #1;
      chk("t5_consumed", q_data.size() - base, 1);
      if (q_data.size() >= base + 1) chk("t5_cons_data", q_data[base], 60);
      chk("t5_valid_clr", int'(pcm_valid), 0);
      chk("t5_ovr_sticky", int'(overrun), 1);

      // reset mid-frame at index ~128
      base = q_data.size(); e0 = err_cnt;
      drive(130, 1'b1, 130);
      @(posedge pwm_clk); #1; rst = 1'b1; pwm_valid_in = 1'b0; pwm_in = 1'b0;
      @(negedge pwm_clk);
      chk("t6_data", int'(pcm_data), 0);
      chk("t6_valid", int'(pcm_valid), 0);
      chk("t6_err", int'(frame_err), 0);
      chk("t6_ovr", int'(overrun), 0);
      @(posedge pwm_clk); #1; rst = 1'b0;
      idle(10);
      chk("t6_no_sample", q_data.size() - base, 0);
      chk("t6_no_err", err_cnt - e0, 0);
      frame(5);
      idle(10);
      chk("t6_count", q_data.size() - base, 1);
      if (q_data.size() >= base + 1) chk("t6_data5", q_data[base], 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
